// File: rtl/ack_pkg.sv
// Shared definitions for the ACK bus: source IDs and the FIFO entry layout.
// ACK_FIFO_TIMESTAMP_EN adds an 8-bit timestamp to each entry.
package ack_pkg;
  localparam int SRC_W = 2;

  localparam logic [SRC_W-1:0] ID_MEM  = 2'b00;
  localparam logic [SRC_W-1:0] ID_SHA  = 2'b01;
  localparam logic [SRC_W-1:0] ID_AES  = 2'b10;
  localparam logic [SRC_W-1:0] ID_CTRL = 2'b11;

  typedef struct packed {
    logic [SRC_W-1:0] src_id;
`ifdef ACK_FIFO_TIMESTAMP_EN
    logic [7:0]       ts;
`endif
  } ack_entry_t;
endpackage

// File: rtl/ack_fifo_mem.sv
// DEPTH x entry register array with one write port and one asynchronous read port.
// Cleared on reset so the head output reads a defined value while empty.
import ack_pkg::*;

module ack_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ack_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ack_entry_t    rdata_o
);
  ack_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ack_event_fifo.sv
// First-word fall-through FIFO capturing arbiter ACK events, with sticky overflow
// and saturating drop counter. ACK_FIFO_TIMESTAMP_EN adds per-entry timestamps on ts_o.
import ack_pkg::*;

module ack_event_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ack_event_i,
  input  logic [SRC_W-1:0] winner_source_id_i,
  input  logic             pop_i,
  input  logic             clr_ovf_i,
  output logic             valid_o,
  output logic [SRC_W-1:0] src_id_o,
  output logic [AW:0]      count_o,
`ifdef ACK_FIFO_TIMESTAMP_EN
  output logic [7:0]       ts_o,
`endif
  output logic             full_o,
  output logic             overflow_o,
  output logic [7:0]       drop_cnt_o
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          full, do_push, do_pop, drop;
  ack_entry_t    wdata, rdata;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // A pop at a full edge frees the slot the incoming entry lands in.
  assign do_push = ack_event_i && (!full || pop_i);
  assign drop    = ack_event_i && full && !pop_i;

`ifdef ACK_FIFO_TIMESTAMP_EN
  logic [7:0] ts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 8'd1;
  end
  assign wdata = '{src_id: winner_source_id_i, ts: ts_q};
  assign ts_o  = rdata.ts;
`else
  assign wdata = '{src_id: winner_source_id_i};
`endif

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // Clear wins for the flag, but a drop on the same edge is still counted.
    if (clr_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  ack_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign valid_o    = (count_q != '0);
  assign full_o     = full;
  assign count_o    = count_q;
  assign src_id_o   = rdata.src_id;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;
endmodule
